// File: rtl/mem_responder.sv
// Byte-wide memory responder: arbitrates a read-only fetch port and a read/write
// data port onto one synchronous RAM, returning one byte per cycle per grant.
module mem_responder #(
    parameter int ADDR_W    = 17,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_en,
    input  logic [ADDR_W-1:0] inst_req_addr,
    output logic              inst_resp_en,
    output logic [7:0]        inst_resp_data,
    input  logic              data_req_en,
    input  logic              data_req_wr,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic [7:0]        data_req_wdata,
    output logic              data_resp_en,
    output logic [7:0]        data_resp_data,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    owner_t           owner;
    owner_t           grant;
    logic [CNT_W-1:0] burst_cnt;
    logic             owner_req;
    logic             other_req;
    logic             limit_hit;

    // The current owner keeps the RAM unless it has used up its burst while the
    // other port waits; with no owner claim, data beats fetch.
    always_comb begin
        owner_req = 1'b0;
        other_req = 1'b0;
        case (owner)
            OWN_INST: begin
                owner_req = inst_req_en;
                other_req = data_req_en;
            end
            OWN_DATA: begin
                owner_req = data_req_en;
                other_req = inst_req_en;
            end
            default: ;
        endcase
        limit_hit = other_req && (burst_cnt == CNT_MAX);

        grant = OWN_IDLE;
        if (owner_req && limit_hit)
            grant = (owner == OWN_INST) ? OWN_DATA : OWN_INST;
        else if (owner_req)
            grant = owner;
        else if (data_req_en)
            grant = OWN_DATA;
        else if (inst_req_en)
            grant = OWN_INST;
    end

    // RAM is quiet while reset is held, regardless of what the requesters present.
    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;
        if (rst) begin
            case (grant)
                OWN_INST: ram_a = inst_req_addr;
                OWN_DATA: begin
                    ram_a    = data_req_addr;
                    ram_wr   = data_req_wr;
                    ram_dout = data_req_wr ? data_req_wdata : 8'h00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner        <= OWN_IDLE;
            burst_cnt    <= '0;
            inst_resp_en <= 1'b0;
            data_resp_en <= 1'b0;
        end else begin
            owner <= grant;
            if (grant != OWN_IDLE && grant == owner) begin
                if (burst_cnt != CNT_MAX)
                    burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt <= '0;
            end
            inst_resp_en <= (grant == OWN_INST) && !flush;
            data_resp_en <= (grant == OWN_DATA);
        end
    end

    // The RAM's registered read data lines up with the registered valids.
    assign inst_resp_data = ram_din;
    assign data_resp_data = ram_din;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the byte-streaming fetch/load interface used by the instruction cache and the data path.
- Arbitrates between two requesters: an instruction-fetch port (read-only) and a data port (read/write).
- Drives a single byte-wide synchronous RAM with 1-cycle read latency.
- Returns one byte per cycle. A requester that pipelines its address (next address presented in the same cycle a response arrives) runs back-to-back with no bubbles.

Parameters:
- ADDR_W, 17: byte address width.
- MAX_BURST, 8: maximum consecutive granted cycles for one owner while the other port is waiting.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- inst_req_en  input  1  fetch request valid, level, may be held across many cycles
- inst_req_addr  input  ADDR_W  fetch byte address
- inst_resp_en  output  1  fetch byte valid
- inst_resp_data  output  8  fetch byte
- data_req_en  input  1  data request valid
- data_req_wr  input  1  1 = write, 0 = read
- data_req_addr  input  ADDR_W  data byte address
- data_req_wdata  input  8  write byte
- data_resp_en  output  1  read byte valid or write acknowledge
- data_resp_data  output  8  read byte (undefined on write ack)
- flush  input  1  synchronous: cancel the pending fetch response
- ram_a  output  ADDR_W  RAM address
- ram_wr  output  1  RAM write strobe
- ram_dout  output  8  RAM write data
- ram_din  input  8  RAM read data, valid the cycle after its address was presented

Behaviour:
- Owner register: IDLE, INST, DATA. Reset value IDLE. Burst counter reset value 0.
- Grant (combinational):
  - If owner is INST or DATA and that owner's req_en is high, and the burst limit is not hit, grant the owner.
  - Otherwise, if data_req_en is high, grant DATA.
  - Otherwise, if inst_req_en is high, grant INST.
  - Otherwise, no grant.
- Burst limit: hit when burst counter == MAX_BURST-1 and the other port's req_en is high. The other port is then granted that cycle.
- Owner update: next owner = granted port, or IDLE if no grant.
- Burst counter:
  - Increments when the granted port equals the current owner.
  - Resets to 0 when ownership changes or nothing is granted.
  - Saturates at MAX_BURST-1.
- RAM drive (combinational from grant):
  - ram_a = granted port's address, else 0.
  - ram_wr = 1 only when DATA is granted with data_req_wr = 1.
  - ram_dout = data_req_wdata when ram_wr = 1, else 0.
  - Fetch port never writes.
- Response, 1-cycle latency:
  - inst_resp_en <= (grant == INST) && !flush.
  - data_resp_en <= (grant == DATA).
  - inst_resp_data = data_resp_data = ram_din (pass-through, meaningful only while the matching resp_en is high).
- Streaming: a request held high with an address changing every cycle gets one response per cycle, in order. The response at cycle t+1 carries the byte for the address granted at cycle t.
- Non-granted requester: sees no response. It must hold req_en and address until granted; no request is dropped.
- Simultaneous first request from IDLE: DATA wins. INST is granted the cycle after data_req_en drops, or at the burst limit.
- Owner drops req_en: the other port may be granted in that same cycle (no idle bubble).
- flush:
  - Suppresses inst_resp_en on the next edge only.
  - Does not change owner.
  - Does not affect the data port.
  - flush with no fetch grant has no effect.
- Reset (rst low, any time, mid-burst included):
  - Immediately: inst_resp_en = 0, data_resp_en = 0, owner = IDLE, counter = 0.
  - While rst is low: ram_wr forced 0; ram_a and ram_dout forced 0.
  - An in-flight response is discarded.
  - First grant is possible on the first edge after rst returns high.
- Address wrap: none; addresses are passed unmodified, ADDR_W bits.

Test Plan:
- Fetch stream, data idle: inst addresses 0x00100..0x00103 on 4 consecutive cycles, RAM holds 0x13,0x05,0x00,0x00 -> inst_resp_en high for 4 consecutive cycles one cycle later, bytes 0x13,0x05,0x00,0x00; ram_wr stays 0.
- Collision: inst_req_en and data read at 0x00200 rise on the same cycle -> DATA granted, ram_a = 0x00200; data_resp_en one cycle later; INST granted the cycle data_req_en falls; the held fetch address is served next.
- Write: data write 0xAB to 0x01000 -> ram_wr = 1, ram_a = 0x01000, ram_dout = 0xAB that cycle; data_resp_en pulse next cycle; later read of 0x01000 returns 0xAB.
- Burst limit, MAX_BURST = 8: fetch held for 20 cycles, data request raised at cycle 2 -> data granted at the 8th consecutive fetch grant; fetch resumes after the data request drops; no fetch byte lost or duplicated.
- flush during stream: flush high at the 3rd fetch grant -> that grant's inst_resp_en suppressed; next fetch response proceeds normally.
- Reset mid-burst: rst low during the 2nd byte of a fetch burst -> inst_resp_en 0 and ram_wr 0 immediately; after release, a new fetch from 0x00000 is answered after 1 cycle.
